// File: rtl/dma_timing_control.sv
// dma_timing_control: master timing FSM of the 8237A-5 style DMA controller.
// Runs the HRQ/HLDA handshake, strobes channel priority selection, and sequences the
// S1-S2-S3-(SW)-S4 transfer cycle with address strobes, bus commands, ADV and EOP.
// Build option: define DMA_EXTENDED_WRITE_EN to start the write command in S2 together
// with the read command (extended write); otherwise the write command starts in S3.
module dma_timing_control #(
    parameter int unsigned NCH      = 4,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic           CLK,
    input  logic           RESET,
    input  logic [NCH-1:0] DMA_REQ,
    input  logic           ACT_DREQ,
    input  logic           CMD_DISABLE,
    input  logic [1:0]     XFER_MODE,
    input  logic [1:0]     XFER_TYPE,
    input  logic           ADDR_HI_CHG,
    input  logic           TC,
    input  logic           HLDA,
    input  logic           READY,
    input  logic           EOP_N_IN,
    output logic           HRQ,
    output logic           PRI_GEN,
    output logic           LD_ACK,
    output logic           AEN,
    output logic           ADSTB,
    output logic           MEMR_N,
    output logic           MEMW_N,
    output logic           IOR_N,
    output logic           IOW_N,
    output logic           ADV,
    output logic           EOP_N_OUT
);

    localparam int unsigned WAIT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

    typedef enum logic [2:0] {
        SI = 3'd0,
        S0 = 3'd1,
        S1 = 3'd2,
        S2 = 3'd3,
        S3 = 3'd4,
        SW = 3'd5,
        S4 = 3'd6
    } dmaState_t;

    dmaState_t         state;
    logic [WAIT_W-1:0] waitCnt;
    logic              endPending;   // TC or external EOP seen during this bus cycle

    logic typeWrite;
    logic typeRead;
    logic modeBlock;
    logic modeDemand;
    logic eopIn;
    logic inBus;
    logic waitExpired;
    logic abortReq;
    logic releaseReq;
    logic s2MemwN;
    logic s2IowN;

    // Transfer type/mode decode; reserved mode acts as single, illegal type as verify
    assign typeWrite  = (XFER_TYPE == 2'b01);
    assign typeRead   = (XFER_TYPE == 2'b10);
    assign modeBlock  = (XFER_MODE == 2'b10);
    assign modeDemand = (XFER_MODE == 2'b00);
    assign eopIn      = !EOP_N_IN;

    // Write command level applied when entering S2
`ifdef DMA_EXTENDED_WRITE_EN
    assign s2MemwN = !typeWrite;
    assign s2IowN  = !typeRead;
`else
    assign s2MemwN = 1'b1;
    assign s2IowN  = 1'b1;
`endif

    // Conditions that send the controller back to idle with everything deasserted
    assign inBus       = (state == S1) || (state == S2) || (state == S3) ||
                         (state == SW) || (state == S4);
    assign waitExpired = (MAX_WAIT != 0) && (state == SW) && !READY &&
                         (waitCnt >= WAIT_LIMIT);
    assign abortReq    = inBus && (!HLDA || waitExpired);
    assign releaseReq  = (state == S4) &&
                         (endPending || !(modeBlock || (modeDemand && ACT_DREQ)));

    // Timing state machine with all outputs registered alongside the state
    always_ff @(posedge CLK) begin
        if (RESET || abortReq || releaseReq) begin
            state      <= SI;
            HRQ        <= 1'b0;
            PRI_GEN    <= 1'b0;
            LD_ACK     <= 1'b0;
            AEN        <= 1'b0;
            ADSTB      <= 1'b0;
            MEMR_N     <= 1'b1;
            MEMW_N     <= 1'b1;
            IOR_N      <= 1'b1;
            IOW_N      <= 1'b1;
            ADV        <= 1'b0;
            EOP_N_OUT  <= 1'b1;
            waitCnt    <= '0;
            endPending <= 1'b0;
        end else begin
            PRI_GEN   <= 1'b0;
            ADSTB     <= 1'b0;
            ADV       <= 1'b0;
            EOP_N_OUT <= 1'b1;
            case (state)
                SI: begin
                    if (|DMA_REQ && !CMD_DISABLE) begin
                        state <= S0;
                        HRQ   <= 1'b1;
                    end
                end
                S0: begin
                    if (HLDA) begin
                        state   <= S1;
                        PRI_GEN <= 1'b1;
                        LD_ACK  <= 1'b1;
                        AEN     <= 1'b1;
                        ADSTB   <= 1'b1;
                    end else if (!(|DMA_REQ)) begin
                        state <= SI;
                        HRQ   <= 1'b0;
                    end
                end
                S1: begin
                    state  <= S2;
                    MEMR_N <= !typeRead;
                    IOR_N  <= !typeWrite;
                    MEMW_N <= s2MemwN;
                    IOW_N  <= s2IowN;
                    if (eopIn) endPending <= 1'b1;
                end
                S2: begin
                    state  <= S3;
                    MEMW_N <= !typeWrite;
                    IOW_N  <= !typeRead;
                    if (eopIn) endPending <= 1'b1;
                end
                S3, SW: begin
                    if (!READY) begin
                        state <= SW;
                        if (eopIn) endPending <= 1'b1;
                        if (state == S3) begin
                            waitCnt <= WAIT_W'(1);
                        end else if (MAX_WAIT != 0) begin
                            waitCnt <= waitCnt + WAIT_W'(1);
                        end
                    end else begin
                        state      <= S4;
                        MEMR_N     <= 1'b1;
                        MEMW_N     <= 1'b1;
                        IOR_N      <= 1'b1;
                        IOW_N      <= 1'b1;
                        ADV        <= 1'b1;
                        EOP_N_OUT  <= !(endPending || eopIn || TC);
                        endPending <= endPending || eopIn || TC;
                        waitCnt    <= '0;
                    end
                end
                S4: begin
                    endPending <= 1'b0;
                    if (ADDR_HI_CHG) begin
                        state <= S1;
                        ADSTB <= 1'b1;
                    end else begin
                        state  <= S2;
                        MEMR_N <= !typeRead;
                        IOR_N  <= !typeWrite;
                        MEMW_N <= s2MemwN;
                        IOW_N  <= s2IowN;
                    end
                end
                default: state <= SI;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_timing_control.sv
// Randomized bench for dma_timing_control: each service is planned as a sequence of
// bus phases and the expected output vector for every clock is derived from that plan.
module tb_dma_timing_control;

    localparam int unsigned NCH      = 4;
    localparam int unsigned MAX_WAIT = 3;
`ifdef DMA_EXTENDED_WRITE_EN
    localparam logic EXT_WR = 1'b1;
`else
    localparam logic EXT_WR = 1'b0;
`endif
    // {HRQ,PRI_GEN,LD_ACK,AEN,ADSTB,MEMR_N,MEMW_N,IOR_N,IOW_N,ADV,EOP_N_OUT}
    localparam logic [10:0] IDLE = 11'b00000_1111_0_1;
    localparam logic [10:0] HOLD = 11'b10000_1111_0_1;

    logic           CLK = 1'b0;
    logic           RESET;
    logic [NCH-1:0] DMA_REQ;
    logic           ACT_DREQ;
    logic           CMD_DISABLE;
    logic [1:0]     XFER_MODE;
    logic [1:0]     XFER_TYPE;
    logic           ADDR_HI_CHG;
    logic           TC;
    logic           HLDA;
    logic           READY;
    logic           EOP_N_IN;
    logic           HRQ, PRI_GEN, LD_ACK, AEN, ADSTB;
    logic           MEMR_N, MEMW_N, IOR_N, IOW_N, ADV, EOP_N_OUT;
    logic [10:0]    obsV;

    int errCount = 0;
    int chkCount = 0;

    dma_timing_control #(.NCH(NCH), .MAX_WAIT(MAX_WAIT)) dut (
        .CLK(CLK), .RESET(RESET), .DMA_REQ(DMA_REQ), .ACT_DREQ(ACT_DREQ),
        .CMD_DISABLE(CMD_DISABLE), .XFER_MODE(XFER_MODE), .XFER_TYPE(XFER_TYPE),
        .ADDR_HI_CHG(ADDR_HI_CHG), .TC(TC), .HLDA(HLDA), .READY(READY),
        .EOP_N_IN(EOP_N_IN), .HRQ(HRQ), .PRI_GEN(PRI_GEN), .LD_ACK(LD_ACK),
        .AEN(AEN), .ADSTB(ADSTB), .MEMR_N(MEMR_N), .MEMW_N(MEMW_N),
        .IOR_N(IOR_N), .IOW_N(IOW_N), .ADV(ADV), .EOP_N_OUT(EOP_N_OUT)
    );

    always #5 CLK = ~CLK;

    assign obsV = {HRQ, PRI_GEN, LD_ACK, AEN, ADSTB, MEMR_N, MEMW_N, IOR_N, IOW_N, ADV, EOP_N_OUT};

    task automatic checkEq(input string tag, input logic [10:0] obs, input logic [10:0] exp);
        chkCount++;
        if (obs !== exp) begin
            errCount++;
            $display("FAIL %s @%0t: got %b want %b", tag, $time, obs, exp);
        end
    endtask

    // Expected vector while servicing: read command = IOR (type 01) / MEMR (type 10)
    function automatic logic [10:0] busVec(input logic pri, input logic adstb, input logic rdOn,
                                           input logic wrOn, input logic adv, input logic eop,
                                           input logic [1:0] typ);
        logic w;
        logic r;
        w = (typ == 2'b01);
        r = (typ == 2'b10);
        busVec = {1'b1, pri, 1'b1, 1'b1, adstb, !(rdOn && r), !(wrOn && w),
                  !(rdOn && w), !(wrOn && r), adv, !eop};
    endfunction

    function automatic logic [NCH-1:0] nzReq();
        nzReq = NCH'($urandom_range(1, (1 << NCH) - 1));
    endfunction

    task automatic doStep(input string tag, input logic [10:0] expV);
        @(posedge CLK);
        #1;
        checkEq(tag, obsV, expV);
    endtask

    task automatic idleInputs();
        RESET       = 1'b0;
        HLDA        = 1'b0;
        ACT_DREQ    = 1'($urandom);
        ADDR_HI_CHG = 1'($urandom);
        TC          = 1'b0;
        READY       = 1'b1;
        EOP_N_IN    = 1'b1;
    endtask

    // Inputs for one clock inside a service; occasionally drops HLDA or pulses RESET
    task automatic busInputs(output bit aborted);
        int r;
        r           = $urandom_range(0, 59);
        RESET       = (r == 0);
        HLDA        = (r >= 3);
        aborted     = (r < 3);
        DMA_REQ     = NCH'($urandom);
        CMD_DISABLE = 1'($urandom);
        ACT_DREQ    = 1'($urandom);
        ADDR_HI_CHG = 1'($urandom);
        TC          = 1'b0;
        READY       = 1'b1;
        EOP_N_IN    = ($urandom_range(0, 11) != 0);
    endtask

    task automatic runService(input int forceMode, input int forceType);
        logic [1:0] mode;
        logic [1:0] typ;
        bit         ab;
        bit         inS1;
        bit         endSeen;
        int         nWait;
        mode      = (forceMode < 0) ? 2'($urandom) : 2'(forceMode);
        typ       = (forceType < 0) ? 2'($urandom) : 2'(forceType);
        XFER_MODE = mode;
        XFER_TYPE = typ;
        repeat ($urandom_range(0, 2)) begin
            idleInputs();
            if ($urandom_range(0, 1) == 0) begin
                DMA_REQ     = '0;
                CMD_DISABLE = 1'($urandom);
            end else begin
                DMA_REQ     = nzReq();
                CMD_DISABLE = 1'b1;
            end
            doStep("idle", IDLE);
        end
        idleInputs();
        DMA_REQ     = nzReq();
        CMD_DISABLE = 1'b0;
        doStep("request", HOLD);
        repeat ($urandom_range(0, 2)) begin
            idleInputs();
            DMA_REQ     = nzReq();
            CMD_DISABLE = 1'($urandom);
            doStep("holdWait", HOLD);
        end
        if ($urandom_range(0, 7) == 0) begin
            idleInputs();
            DMA_REQ = '0;
            doStep("holdCancel", IDLE);
            return;
        end
        idleInputs();
        HLDA        = 1'b1;
        DMA_REQ     = nzReq();
        CMD_DISABLE = 1'($urandom);
        doStep("grant", busVec(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, typ));
        inS1    = 1'b1;
        endSeen = 1'b0;
        forever begin
            if (inS1) begin
                busInputs(ab);
                if (ab) begin doStep("abortS1", IDLE); return; end
                endSeen = endSeen || !EOP_N_IN;
                doStep("enterS2", busVec(1'b0, 1'b0, 1'b1, EXT_WR, 1'b0, 1'b0, typ));
            end
            busInputs(ab);
            if (ab) begin doStep("abortS2", IDLE); return; end
            endSeen = endSeen || !EOP_N_IN;
            doStep("enterS3", busVec(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, typ));
            nWait = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, MAX_WAIT + 1);
            for (int k = 0; k <= nWait; k++) begin
                busInputs(ab);
                if (ab) begin doStep("abortS3", IDLE); return; end
                if (k < nWait) begin
                    READY = 1'b0;
                    if (k >= 1 && k >= int'(MAX_WAIT)) begin
                        doStep("waitLimit", IDLE);
                        return;
                    end
                    endSeen = endSeen || !EOP_N_IN;
                    doStep("waitState", busVec(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, typ));
                end else begin
                    TC      = ($urandom_range(0, 4) == 0);
                    endSeen = endSeen || !EOP_N_IN || TC;
                    doStep("enterS4", busVec(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, endSeen, typ));
                end
            end
            busInputs(ab);
            if (ab) begin doStep("abortS4", IDLE); return; end
            EOP_N_IN = 1'b1;
            if (endSeen || mode == 2'b01 || mode == 2'b11 || (mode == 2'b00 && !ACT_DREQ)) begin
                doStep("release", IDLE);
                return;
            end
            endSeen = 1'b0;
            inS1    = ADDR_HI_CHG;
            if (inS1) doStep("nextS1", busVec(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, typ));
            else      doStep("nextS2", busVec(1'b0, 1'b0, 1'b1, EXT_WR, 1'b0, 1'b0, typ));
        end
    endtask

    initial begin
        idleInputs();
        RESET       = 1'b1;
        DMA_REQ     = nzReq();
        CMD_DISABLE = 1'b0;
        XFER_MODE   = 2'b01;
        XFER_TYPE   = 2'b01;
        doStep("reset", IDLE);
        doStep("resetHeld", IDLE);
        idleInputs();
        DMA_REQ = '0;
        doStep("idleAfterReset", IDLE);
        runService(1, 1);
        runService(2, 2);
        runService(0, 1);
        repeat (400) runService(-1, -1);
        $display("Result: errors=%0d of %0d checks", errCount, chkCount);
        $finish;
    end

endmodule
